// File: rtl/link_rx_checker.sv
// Receive-side link checker: decodes {X, INV1} bus words, compares them against a buffered
// expected stream and reports run statistics. Define RX_TOGGLE_CNT_EN to enable bus toggle counting.

// Segment-invert decoder: payload bit b belongs to segment b/A, which is inverted by
// INV1[(b/A) % (M-1)] XOR the global invert INV1[M-1]. INV1 == 0 is the identity.
module my_decoder #(
  parameter int M = 5,
  parameter int k = 32,
  parameter int A = 8
) (
  input  logic [k+M-1:0] code_in,
  output logic [k-1:0]   data_out
);
  logic [M-1:0] inv;
  assign inv = code_in[M-1:0];

  always_comb begin
    data_out = code_in[k+M-1:M];
    for (int unsigned b = 0; b < k; b++) begin
      data_out[b] = code_in[M+b] ^ inv[(b / A) % (M - 1)] ^ inv[M-1];
    end
  end
endmodule

module link_rx_checker #(
  parameter int M     = 5,
  parameter int k     = 32,
  parameter int A     = 8,
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [15:0]    num_words,
  input  logic           bus_valid,
  output logic           bus_ready,
  input  logic [k+M-1:0] bus_in,
  input  logic           ref_valid,
  output logic           ref_ready,
  input  logic [k-1:0]   ref_data,
  output logic           dec_valid,
  input  logic           dec_ready,
  output logic [k-1:0]   dec_data,
  output logic           busy,
  output logic           done,
  output logic [15:0]    word_cnt,
  output logic [15:0]    err_cnt,
  output logic [15:0]    first_err,
  output logic           err_seen,
  output logic [21:0]    toggle_sum
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [15:0] num_q;
  logic [k-1:0] dec_word;
  logic bus_fire, dec_fire, start_ok, last_accept;

  my_decoder #(.M(M), .k(k), .A(A)) u_dec (
    .code_in  (bus_in),
    .data_out (dec_word)
  );

  assign bus_ready   = (state == S_RUN) && (!dec_valid || dec_ready);
  assign bus_fire    = bus_valid && bus_ready;
  assign dec_fire    = dec_valid && dec_ready;
  assign start_ok    = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_accept = bus_fire && ((word_cnt + 16'd1) == num_q);
  assign busy        = (state == S_RUN) || (state == S_DRAIN);
  assign done        = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = (num_words == '0) ? S_DONE : S_RUN;
      S_RUN:          if (last_accept) state_nxt = S_DRAIN;
      S_DRAIN:        if (!dec_valid) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_valid <= 1'b0;
      dec_data  <= '0;
    end else if (bus_fire) begin
      dec_valid <= 1'b1;
      dec_data  <= dec_word;
    end else if (dec_ready) begin
      dec_valid <= 1'b0;
    end
  end

  // Expected-data FIFO; full refuses a push even when a pop happens in the same cycle.
  logic [k-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic full, empty, push, pop, mismatch;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign ref_ready = !full;
  assign push      = ref_valid && !full;
  assign pop       = dec_fire && !empty;
  assign mismatch  = dec_fire && (empty || (mem[rd_ptr] != dec_data));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ref_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Only one word sits in the decode stage, so its index is the pre-increment word_cnt - 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q     <= '0;
      word_cnt  <= '0;
      err_cnt   <= '0;
      first_err <= '0;
      err_seen  <= 1'b0;
    end else if (start_ok) begin
      num_q     <= num_words;
      word_cnt  <= '0;
      err_cnt   <= '0;
      first_err <= '0;
      err_seen  <= 1'b0;
    end else begin
      if (bus_fire) word_cnt <= word_cnt + 16'd1;
      if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
        if (!err_seen) begin
          err_seen  <= 1'b1;
          first_err <= word_cnt - 16'd1;
        end
      end
    end
  end

`ifdef RX_TOGGLE_CNT_EN
  logic [k+M-1:0] prev_word, diff;
  logic [22:0]    toggle_add;

  assign diff = bus_in ^ prev_word;

  always_comb begin
    toggle_add = {1'b0, toggle_sum};
    for (int unsigned i = 0; i < k + M; i++) begin
      toggle_add = toggle_add + 23'(diff[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_word  <= '0;
      toggle_sum <= '0;
    end else if (start_ok) begin
      prev_word  <= '0;
      toggle_sum <= '0;
    end else if (bus_fire) begin
      prev_word  <= bus_in;
      toggle_sum <= toggle_add[22] ? '1 : toggle_add[21:0];
    end
  end
`else
  assign toggle_sum = '0;
`endif

endmodule
